// File: rtl/qed_pkg.sv
// Shared definitions for the QED instruction-buffer writer and reader.
// Address layout constants must match on both sides of the buffer.
package qed_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } qed_state_e;

  localparam logic [31:0] QED_FIRST_ADDR = 32'h4;
  localparam logic [31:0] QED_WORD_STEP  = 32'h4;

endpackage

// File: rtl/qed_skid_fifo.sv
// Two-entry skid FIFO; head word comes straight from storage flops.
// Flush empties the FIFO and takes priority over push/pop.
module qed_skid_fifo #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        cnt_q;
  logic              do_push;
  logic              do_pop;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/qed_mem_reader.sv
// Streams committed QED instruction words back out of the buffer memory
// as a valid/ready stream, tracking the writer's address for occupancy.
module qed_mem_reader
  import qed_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(QED_FIRST_ADDR),
  parameter int unsigned       STEP       = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              wr_en_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic              instr_vld_o,
  output logic [DATA_W-1:0] instr_o,
  input  logic              instr_rdy_i,
  output logic              busy_o,
  output logic [15:0]       rd_count_o
);

  qed_state_e        state_q;
  qed_state_e        state_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] lim_q;
  logic [ADDR_W-1:0] lim_c_q;
  logic              lim_vld_q;
  logic              lim_cv_q;
  logic              inflight_q;
  logic [15:0]       cnt_q;

  logic              avail;
  logic              slots_ok;
  logic              pop;
  logic              push;
  logic              drained;
  logic [1:0]        fifo_cnt;
  logic              fifo_full;
  logic              fifo_empty;

  // lim_c trails lim by a cycle: the memory commits the write on that edge
  assign avail = lim_cv_q &&
                 (rd_addr_q != lim_c_q + ADDR_W'(STEP));

  assign pop      = instr_vld_o && instr_rdy_i;
  assign push     = inflight_q && !start_i;
  assign slots_ok = pop ||
                    (!fifo_full && !(inflight_q && !fifo_empty));
  assign drained  = !inflight_q &&
                    (fifo_empty || (fifo_cnt == 2'd1 && pop));

  assign instr_vld_o   = !fifo_empty;
  assign mem_rd_addr_o = rd_addr_q;
  assign rd_count_o    = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = FETCH;
    end else begin
      unique case (state_q)
        FETCH:   if (stop_i) state_d = DRAIN;
        DRAIN:   if (drained) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    mem_rd_en_o = 1'b0;
    busy_o      = (state_q != IDLE);
    unique case (state_q)
      FETCH:   mem_rd_en_o = avail && slots_ok &&
                             !stop_i && !start_i;
      default: mem_rd_en_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_addr_q  <= FIRST_ADDR;
      lim_q      <= '0;
      lim_c_q    <= '0;
      lim_vld_q  <= 1'b0;
      lim_cv_q   <= 1'b0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (wr_en_i) begin
        lim_q     <= wr_addr_i;
        lim_vld_q <= 1'b1;
      end
      lim_c_q    <= lim_q;
      lim_cv_q   <= lim_vld_q;
      inflight_q <= mem_rd_en_o;
      if (start_i) begin
        rd_addr_q <= FIRST_ADDR;
        cnt_q     <= '0;
      end else begin
        if (mem_rd_en_o) rd_addr_q <= rd_addr_q + ADDR_W'(STEP);
        if (pop)         cnt_q     <= cnt_q + 16'd1;
      end
    end
  end

  qed_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (start_i),
    .data_i  (mem_rd_data_i),
    .data_o  (instr_o),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_qed_mem_reader.sv
// Directed bench for qed_mem_reader: a default instance plus one whose
// first address sits just below the 32-bit wrap point.
module tb_qed_mem_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] mem [16];

  logic        start_a = 0, stop_a = 0, rdy_a = 0;
  logic        rd_en_a, vld_a, busy_a;
  logic [31:0] rd_addr_a, rd_data_a, instr_a;
  logic [15:0] cnt_a;

  logic        start_b = 0, stop_b = 0, rdy_b = 0;
  logic        rd_en_b, vld_b, busy_b;
  logic [31:0] rd_addr_b, rd_data_b, instr_b;
  logic [15:0] cnt_b;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_rd_a = 0, n_rd_b = 0;
  int          got_n_a = 0, got_n_b = 0;
  logic [31:0] got_a [64];
  logic [31:0] got_b [64];
  int          rd0, g0;

  always #5 clk = ~clk;

  qed_mem_reader u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start_a),
    .stop_i        (stop_a),
    .wr_addr_i     (wr_addr),
    .wr_en_i       (wr_en),
    .mem_rd_en_o   (rd_en_a),
    .mem_rd_addr_o (rd_addr_a),
    .mem_rd_data_i (rd_data_a),
    .instr_vld_o   (vld_a),
    .instr_o       (instr_a),
    .instr_rdy_i   (rdy_a),
    .busy_o        (busy_a),
    .rd_count_o    (cnt_a)
  );

  qed_mem_reader #(
    .FIRST_ADDR (32'hFFFF_FFFC)
  ) u_wrap (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start_b),
    .stop_i        (stop_b),
    .wr_addr_i     (wr_addr),
    .wr_en_i       (wr_en),
    .mem_rd_en_o   (rd_en_b),
    .mem_rd_addr_o (rd_addr_b),
    .mem_rd_data_i (rd_data_b),
    .instr_vld_o   (vld_b),
    .instr_o       (instr_b),
    .instr_rdy_i   (rdy_b),
    .busy_o        (busy_b),
    .rd_count_o    (cnt_b)
  );

  always @(posedge clk) begin
    if (wr_en) mem[wr_addr[5:2]] <= wr_data;
    rd_data_a <= mem[rd_addr_a[5:2]];
    rd_data_b <= mem[rd_addr_b[5:2]];
  end

  always @(negedge clk) begin
    if (rd_en_a) n_rd_a++;
    if (rd_en_b) n_rd_b++;
    if (vld_a && rdy_a) begin
      got_a[got_n_a[5:0]] = instr_a;
      got_n_a++;
    end
    if (vld_b && rdy_b) begin
      got_b[got_n_b[5:0]] = instr_b;
      got_n_b++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_word(logic [31:0] a, logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    cyc();
    wr_en   = 1'b0;
  endtask

  initial begin
    repeat (2) cyc();
    #1;
    chk("rst_rd_en", 32'(rd_en_a), 0);
    chk("rst_rd_addr", rd_addr_a, 32'h4);
    chk("rst_vld", 32'(vld_a), 0);
    chk("rst_instr", instr_a, 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_cnt", 32'(cnt_a), 0);
    rst_n = 1'b1;
    cyc();

    // streaming with an always-ready consumer
    wr_word(32'h4, 32'hAAAA_0001);
    wr_word(32'h8, 32'hAAAA_0002);
    wr_word(32'hC, 32'hAAAA_0003);
    cyc(); cyc();
    rd0 = n_rd_a; g0 = got_n_a;
    start_a = 1; rdy_a = 1;
    #1 chk("t1_idle_rd", 32'(rd_en_a), 0);
    cyc(); start_a = 0;
    #1 chk("t1_rd0_en", 32'(rd_en_a), 1);
    chk("t1_rd0_addr", rd_addr_a, 32'h4);
    cyc(); #1;
    chk("t1_rd1_en", 32'(rd_en_a), 1);
    chk("t1_rd1_addr", rd_addr_a, 32'h8);
    cyc(); #1;
    chk("t1_rd2_en", 32'(rd_en_a), 1);
    chk("t1_rd2_addr", rd_addr_a, 32'hC);
    cyc(); #1;
    chk("t1_empty_rd", 32'(rd_en_a), 0);
    repeat (3) cyc();
    #1;
    chk("t1_reads", n_rd_a - rd0, 3);
    chk("t1_words", got_n_a - g0, 3);
    chk("t1_w0", got_a[6'(g0)], 32'hAAAA_0001);
    chk("t1_w1", got_a[6'(g0 + 1)], 32'hAAAA_0002);
    chk("t1_w2", got_a[6'(g0 + 2)], 32'hAAAA_0003);
    chk("t1_cnt", 32'(cnt_a), 3);
    stop_a = 1; cyc(); stop_a = 0;
    cyc(); cyc();
    #1 chk("t1_idle", 32'(busy_a), 0);

    // consumer stalls for five cycles after the first valid
    rd0 = n_rd_a; g0 = got_n_a;
    start_a = 1; rdy_a = 0;
    cyc(); start_a = 0;
    #1 chk("t2_rd0_addr", rd_addr_a, 32'h4);
    cyc(); #1;
    chk("t2_rd1_addr", rd_addr_a, 32'h8);
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_hold_vld", 32'(vld_a), 1);
      chk("t2_hold_instr", instr_a, 32'hAAAA_0001);
      chk("t2_hold_nord", 32'(rd_en_a), 0);
      cyc();
    end
    chk("t2_reads_stall", n_rd_a - rd0, 2);
    rdy_a = 1;
    repeat (5) cyc();
    #1;
    chk("t2_reads", n_rd_a - rd0, 3);
    chk("t2_words", got_n_a - g0, 3);
    chk("t2_w0", got_a[6'(g0)], 32'hAAAA_0001);
    chk("t2_w1", got_a[6'(g0 + 1)], 32'hAAAA_0002);
    chk("t2_w2", got_a[6'(g0 + 2)], 32'hAAAA_0003);
    chk("t2_cnt", 32'(cnt_a), 3);
    stop_a = 1; cyc(); stop_a = 0;
    cyc(); cyc();

    // stop with two words buffered
    rd0 = n_rd_a; g0 = got_n_a;
    start_a = 1; rdy_a = 0;
    cyc(); start_a = 0;
    cyc(); cyc(); cyc();
    stop_a = 1;
    #1 chk("t4_vld", 32'(vld_a), 1);
    cyc(); stop_a = 0; rdy_a = 1;
    #1 chk("t4_drain_busy", 32'(busy_a), 1);
    chk("t4_drain_nord", 32'(rd_en_a), 0);
    cyc(); #1;
    chk("t4_last_busy", 32'(busy_a), 1);
    cyc(); #1;
    chk("t4_idle_busy", 32'(busy_a), 0);
    chk("t4_idle_vld", 32'(vld_a), 0);
    chk("t4_words", got_n_a - g0, 2);
    chk("t4_w0", got_a[6'(g0)], 32'hAAAA_0001);
    chk("t4_w1", got_a[6'(g0 + 1)], 32'hAAAA_0002);
    chk("t4_reads", n_rd_a - rd0, 2);

    // asynchronous reset mid-stream, then restart with no committed words
    rdy_a = 0; start_a = 1;
    cyc(); start_a = 0;
    cyc(); cyc();
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", 32'(vld_a), 0);
    chk("t5_rst_instr", instr_a, 0);
    chk("t5_rst_busy", 32'(busy_a), 0);
    chk("t5_rst_rd_en", 32'(rd_en_a), 0);
    chk("t5_rst_addr", rd_addr_a, 32'h4);
    cyc(); rst_n = 1'b1;
    cyc();
    rd0 = n_rd_a; g0 = got_n_a;
    start_a = 1; rdy_a = 1;
    cyc(); start_a = 0;
    #1;
    chk("t5_busy", 32'(busy_a), 1);
    chk("t5_cnt", 32'(cnt_a), 0);
    chk("t5_nolim_rd", 32'(rd_en_a), 0);
    cyc(); #1;
    chk("t5_nolim_rd2", 32'(rd_en_a), 0);
    wr_word(32'h4, 32'h1234_5678);
    #1 chk("t3_w1_rd", 32'(rd_en_a), 0);
    cyc(); #1;
    chk("t3_w2_rd", 32'(rd_en_a), 1);
    chk("t3_w2_addr", rd_addr_a, 32'h4);
    cyc(); #1;
    chk("t3_w3_rd", 32'(rd_en_a), 0);
    repeat (3) cyc();
    #1;
    chk("t3_words", got_n_a - g0, 1);
    chk("t3_w0", got_a[6'(g0)], 32'h1234_5678);
    chk("t3_cnt", 32'(cnt_a), 1);
    chk("t3_reads", n_rd_a - rd0, 1);
    stop_a = 1; cyc(); stop_a = 0;
    cyc(); cyc();

    // address wrap on the second instance
    wr_word(32'hFFFF_FFFC, 32'hBBBB_0001);
    wr_word(32'h0, 32'hBBBB_0002);
    cyc(); cyc();
    rd0 = n_rd_b; g0 = got_n_b;
    start_b = 1; rdy_b = 1;
    cyc(); start_b = 0;
    #1;
    chk("t6_rd0_en", 32'(rd_en_b), 1);
    chk("t6_rd0_addr", rd_addr_b, 32'hFFFF_FFFC);
    cyc(); #1;
    chk("t6_rd1_en", 32'(rd_en_b), 1);
    chk("t6_rd1_addr", rd_addr_b, 32'h0);
    cyc(); #1;
    chk("t6_empty_rd", 32'(rd_en_b), 0);
    repeat (3) cyc();
    #1;
    chk("t6_words", got_n_b - g0, 2);
    chk("t6_w0", got_b[6'(g0)], 32'hBBBB_0001);
    chk("t6_w1", got_b[6'(g0 + 1)], 32'hBBBB_0002);
    chk("t6_cnt", 32'(cnt_b), 2);
    chk("t6_reads", n_rd_b - rd0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
